// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Frame-level round-robin arbiter sharing one GMII transmit path between the
//   ARP (0), ICMP (1) and UDP (2) transmit engines. A grant issues a one-cycle
//   start pulse. The owner's byte stream is forwarded through a registered mux
//   until its done pulse. A minimum inter-frame gap is then enforced.
//
//   Optional build macro GMII_TX_ARB_TIMEOUT_EN adds a watchdog. The watchdog
//   releases a source that stays BUSY for TIMEOUT_CYCLES cycles without a done.
//
// Parameters
//   IFG_CYCLES      idle cycles forced after each frame (values below 1 act as 1)
//   TIMEOUT_CYCLES  maximum BUSY duration before forced release (timeout build)
// Ports
//   clk, rst          GMII TX clock; asynchronous active-high reset
//   req[2:0]          level requests per source
//   start[2:0]        one-cycle grant/start pulse to the selected source
//   done[2:0]         one-cycle frame-complete pulse per source
//   src_tx_en[2:0]    per-source GMII enable
//   src_txd[23:0]     per-source GMII data, byte lane = source index
//   gmii_tx_en/txd    registered muxed GMII output
//   busy              high from grant until the inter-frame gap ends
//   owner[1:0]        index of the current/last granted source
//   timeout_err       one-cycle pulse when the watchdog releases a hung source
module gmii_tx_arbiter #(
   parameter int unsigned IFG_CYCLES     = 12,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   output logic [2:0]  start,
   input  logic [2:0]  done,
   input  logic [2:0]  src_tx_en,
   input  logic [23:0] src_txd,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic        busy,
   output logic [1:0]  owner,
   output logic        timeout_err
);

   localparam int unsigned IfgLoad = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
   localparam int unsigned IfgW    = $clog2(IfgLoad + 1);
   localparam logic [IfgW-1:0] IfgInit = IfgW'(IfgLoad - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StIfg} state_e;

   state_e          state_q, state_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      last_q, last_d;
   logic [2:0]      start_q, start_d;
   logic            busy_q, busy_d;
   logic            tx_en_q, tx_en_d;
   logic [7:0]      txd_q, txd_d;
   logic [IfgW-1:0] ifg_cnt_q, ifg_cnt_d;

   logic            own_done, own_en;
   logic [7:0]      own_txd;
   logic [1:0]      sel;
   logic            wdog_hit;

   // First requester searching upward from last+1 with wrap.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
      logic [1:0] pick;
      unique case (last)
         2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
         2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
         default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
      endcase
      return pick;
   endfunction

   always_comb begin
      own_done = 1'b0;
      own_en   = 1'b0;
      own_txd  = 8'h00;
      unique case (owner_q)
         2'd0:    begin own_done = done[0]; own_en = src_tx_en[0]; own_txd = src_txd[7:0];   end
         2'd1:    begin own_done = done[1]; own_en = src_tx_en[1]; own_txd = src_txd[15:8];  end
         default: begin own_done = done[2]; own_en = src_tx_en[2]; own_txd = src_txd[23:16]; end
      endcase
   end

   assign sel = rr_pick(req, last_q);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      start_d   = 3'b000;
      busy_d    = busy_q;
      tx_en_d   = 1'b0;
      txd_d     = 8'h00;
      ifg_cnt_d = ifg_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req != 3'b000) begin
               state_d = StBusy;
               owner_d = sel;
               last_d  = sel;
               start_d = 3'b001 << sel;
               busy_d  = 1'b1;
            end
         end
         StBusy: begin
            tx_en_d = own_en;
            txd_d   = own_txd;
            // done takes priority over a watchdog expiry in the same cycle.
            if (own_done || wdog_hit) begin
               state_d   = StIfg;
               ifg_cnt_d = IfgInit;
            end
         end
         StIfg: begin
            if (ifg_cnt_q == '0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               ifg_cnt_d = ifg_cnt_q - IfgW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         owner_q   <= 2'd0;
         last_q    <= 2'd2;
         start_q   <= 3'b000;
         busy_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         txd_q     <= 8'h00;
         ifg_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         tx_en_q   <= tx_en_d;
         txd_q     <= txd_d;
         ifg_cnt_q <= ifg_cnt_d;
      end
   end

`ifdef GMII_TX_ARB_TIMEOUT_EN
   logic [23:0] wdog_q, wdog_d;
   logic        tmo_q, tmo_d;

   // Held at zero outside BUSY, so it reads 0 in the first BUSY cycle after a grant.
   always_comb begin
      wdog_d = (state_q == StBusy) ? wdog_q + 24'd1 : 24'd0;
      tmo_d  = (state_q == StBusy) && wdog_hit && !own_done;
   end

   assign wdog_hit = (state_q == StBusy) && (wdog_q == TIMEOUT_CYCLES - 24'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= 24'd0;
         tmo_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         tmo_q  <= tmo_d;
      end
   end

   assign timeout_err = tmo_q;
`else
   logic unused_timeout_param;
   assign unused_timeout_param = ^TIMEOUT_CYCLES;
   assign wdog_hit    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign start      = start_q;
   assign busy       = busy_q;
   assign owner      = owner_q;
   assign gmii_tx_en = tx_en_q;
   assign gmii_txd   = txd_q;

endmodule

// File: doc/gmii_tx_arbiter.md
# gmii_tx_arbiter

Frame-level arbiter sharing the single GMII transmit path between the ARP, ICMP and UDP transmit engines. It grants one source at a time using round-robin, issues a one-cycle start pulse, forwards that source's GMII byte stream through a registered mux, enforces a minimum inter-frame gap, and can recover from a hung source with a watchdog. It sits between the protocol TX engines and the GMII/RGMII output stage, replacing ad-hoc per-protocol switching.

## Interface
- IFG_CYCLES, 12: idle cycles forced after each frame; values below 1 behave as 1.
- TIMEOUT_CYCLES, 24'hFFFFFF: maximum BUSY duration before forced release (timeout build only).
- clk  in  1  GMII TX clock, 125 MHz.
- rst  in  1  reset, asynchronous, active-high.
- req  in  3  level requests; bit0 ARP, bit1 ICMP, bit2 UDP.
- start  out  3  one-cycle grant/start pulse to the selected source.
- done  in  3  one-cycle frame-complete pulse per source.
- src_tx_en  in  3  per-source GMII enable.
- src_txd  in  24  per-source GMII data; [7:0] ARP, [15:8] ICMP, [23:16] UDP.
- gmii_tx_en  out  1  registered muxed enable.
- gmii_txd  out  8  registered muxed data.
- busy  out  1  high from grant until the IFG ends.
- owner  out  2  index of the current/last granted source.
- timeout_err  out  1  one-cycle pulse when the watchdog releases a hung source.

## Operation
- FSM states: IDLE, BUSY, IFG.
- IDLE: if req != 0, select the first requesting bit searching from (last+1) mod 3 upward with wrap. Next cycle: state=BUSY, owner=sel, last=sel, start[sel]=1 for exactly one cycle, busy=1.
- BUSY: the gmii outputs register src_tx_en/src_txd of owner. On done[owner], go to IFG. done bits of non-owners are ignored. A req drop while BUSY is ignored, and the frame runs to done.
- IFG: gmii_tx_en=0, gmii_txd=0, busy=1. A down-counter loaded with max(IFG_CYCLES,1) expires, then the FSM goes to IDLE with busy=0.
- Outside BUSY, the gmii outputs are 0 regardless of src inputs.
- Round-robin pointer `last` resets to 2, so ARP has first priority after reset.
- Reset values: start=0, gmii_tx_en=0, gmii_txd=0, busy=0, owner=0, timeout_err=0, state=IDLE.
- Reset mid-frame: outputs clear immediately (async). After release the FSM starts in IDLE and ignores stale done pulses.

## Timing
- req high sampled at cycle N in IDLE -> start and busy high at N+1.
- gmii_* at cycle k+1 = src_*[owner] at cycle k while the state at k is BUSY. Latency is 1 cycle.
- done at cycle M -> the data sampled at M is still forwarded at M+1. IFG occupies M+1..M+IFG_CYCLES, IDLE is at M+IFG_CYCLES+1, and the earliest next start is at M+IFG_CYCLES+2.
- done is accepted in the first BUSY cycle (same cycle as start).
- done and watchdog expiry in the same cycle: done wins and there is no timeout_err.

## Configuration
- Macro GMII_TX_ARB_TIMEOUT_EN.
- When defined: a 24-bit counter clears on grant and increments each BUSY cycle. When it reaches TIMEOUT_CYCLES-1 without done[owner], timeout_err pulses one cycle and the FSM enters IFG.
- When undefined: no counter is built, timeout_err is tied 0, and BUSY persists until done[owner].

## Test plan
- Reset, then req=3'b001: start=3'b001 one cycle later. Forward an ARP byte sequence 0x55,0x55,0xD5 and confirm it appears on gmii_txd one cycle delayed. After done, confirm gmii_tx_en=0 for 12 cycles.
- req=3'b111 held continuously: grant order is ARP, ICMP, UDP, ARP, with 12 idle cycles between each frame's last byte and the next start.
- ICMP busy, and done[0] plus a src_tx_en[0] pulse from ARP: no effect on gmii outputs and the frame continues. Then req[0] is granted after the ICMP IFG.
- With the macro and TIMEOUT_CYCLES=100: grant UDP and withhold done. timeout_err pulses at BUSY cycle 100, 12 IFG cycles follow, then the next requester is granted. Without the macro, the arbiter stays BUSY for more than 1000 cycles.
- Assert rst mid-frame at byte 20: gmii_tx_en, busy and start drop asynchronously. After release, req=3'b010 is granted ICMP (last=2 so order resumes from ARP, and ARP is not requesting).
- done[owner] in the same cycle as start: IFG is entered next cycle, with one forwarded byte.
